// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the adder pipeline
// (align, add/normalise, rounding stages).
//   EXP_W/FRAC_W/MANT_W : IEEE-754 single field widths, MANT_W includes G/R/S
//   fp_unpacked_t       : sign, effective exponent, significand with hidden bit, class flags
//   fp_unpack()         : splits a raw single into fp_unpacked_t
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int SIG_W  = FRAC_W + 1;
    localparam int MANT_W = 27;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [SIG_W-1:0]  sig;
        logic              is_nan;
        logic              is_inf;
    } fp_unpacked_t;

    // Zeros and denormals get exponent 1 so they line up with the smallest normals.
    function automatic fp_unpacked_t fp_unpack(input logic [31:0] x);
        fp_unpacked_t u;
        logic hidden;
        hidden   = |x[30:23];
        u.sign   = x[31];
        u.exp    = hidden ? x[30:23] : 8'd1;
        u.sig    = {hidden, x[22:0]};
        u.is_nan = (x[30:23] == EXP_MAX) && (|x[22:0]);
        u.is_inf = (x[30:23] == EXP_MAX) && !(|x[22:0]);
        return u;
    endfunction

endpackage

// File: rtl/fp_rshift_sticky.sv
// Combinational right shifter with sticky collection.
//   val   : MANT_W-bit value to shift
//   shamt : shift amount, saturates at MANT_W
//   res   : shifted value; bit 0 is ORed with every bit shifted out
module fp_rshift_sticky
    import fp_pkg::*;
(
    input  logic [MANT_W-1:0] val,
    input  logic [EXP_W-1:0]  shamt,
    output logic [MANT_W-1:0] res
);

    logic [MANT_W-1:0] lost_mask;

    always_comb begin
        lost_mask = '0;
        res       = '0;
        if (shamt >= 8'(MANT_W)) begin
            // Everything falls off the end: only the sticky bit survives.
            res[0] = |val;
        end else begin
            lost_mask = ~({MANT_W{1'b1}} << shamt);
            res       = val >> shamt;
            res[0]    = res[0] | (|(val & lost_mask));
        end
    end

endmodule

// File: rtl/fp_align_stage.sv
// Two-stage operand alignment front end of the FP adder.
//   A, B, in_valid, in_ready      : operand pair handshake (in_ready forced low in reset)
//   out_valid, out_ready          : result handshake, outputs held while stalled
//   big_sign, eff_sub, exp_out    : sign of larger operand, sign difference, common exponent
//   mant_big, mant_small          : 27-bit significands, small one aligned with sticky
//   nan, inf, inf_sign            : special-value result flags
// Stage 1 holds unpacked/ordered fields, stage 2 holds the aligned outputs.
module fp_align_stage
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       A,
    input  logic [31:0]       B,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              big_sign,
    output logic              eff_sub,
    output logic [EXP_W-1:0]  exp_out,
    output logic [MANT_W-1:0] mant_big,
    output logic [MANT_W-1:0] mant_small,
    output logic              nan,
    output logic              inf,
    output logic              inf_sign
);

    fp_unpacked_t ua, ub;
    logic             swap;
    logic             big_sign0, nan0, inf0, inf_sign0;
    logic [EXP_W-1:0] big_exp0, small_exp0;
    logic [SIG_W-1:0] big_sig0, small_sig0;

    always_comb begin
        ua   = fp_unpack(A);
        ub   = fp_unpack(B);
        // Magnitude order on raw {exp, frac}; ties keep A as the big operand.
        swap       = B[30:0] > A[30:0];
        big_sign0  = swap ? ub.sign : ua.sign;
        big_exp0   = swap ? ub.exp  : ua.exp;
        small_exp0 = swap ? ua.exp  : ub.exp;
        big_sig0   = swap ? ub.sig  : ua.sig;
        small_sig0 = swap ? ua.sig  : ub.sig;
        nan0       = ua.is_nan | ub.is_nan | (ua.is_inf & ub.is_inf & (ua.sign ^ ub.sign));
        inf0       = !nan0 & (ua.is_inf | ub.is_inf);
        inf_sign0  = ua.is_inf ? ua.sign : ub.sign;
    end

    // Handshake: a stage loads whenever it is empty or its successor drains.
    logic s1_valid, s2_valid, s1_adv, s2_adv;
    assign s2_adv    = !s2_valid | out_ready;
    assign s1_adv    = !s1_valid | s2_adv;
    assign in_ready  = rst & s1_adv;
    assign out_valid = s2_valid;

    logic             s1_big_sign, s1_eff_sub, s1_nan, s1_inf, s1_inf_sign;
    logic [EXP_W-1:0] s1_exp, s1_d;
    logic [SIG_W-1:0] s1_sig_big, s1_sig_small;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid     <= 1'b0;
            s1_big_sign  <= 1'b0;
            s1_eff_sub   <= 1'b0;
            s1_nan       <= 1'b0;
            s1_inf       <= 1'b0;
            s1_inf_sign  <= 1'b0;
            s1_exp       <= '0;
            s1_d         <= '0;
            s1_sig_big   <= '0;
            s1_sig_small <= '0;
        end else if (s1_adv) begin
            s1_valid     <= in_valid;
            s1_big_sign  <= big_sign0;
            s1_eff_sub   <= A[31] ^ B[31];
            s1_nan       <= nan0;
            s1_inf       <= inf0;
            s1_inf_sign  <= inf_sign0;
            s1_exp       <= big_exp0;
            s1_d         <= big_exp0 - small_exp0;
            s1_sig_big   <= big_sig0;
            s1_sig_small <= small_sig0;
        end
    end

    logic [MANT_W-1:0] small_aligned;

    fp_rshift_sticky u_shift (
        .val   ({s1_sig_small, 3'b000}),
        .shamt (s1_d),
        .res   (small_aligned)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid   <= 1'b0;
            big_sign   <= 1'b0;
            eff_sub    <= 1'b0;
            exp_out    <= '0;
            mant_big   <= '0;
            mant_small <= '0;
            nan        <= 1'b0;
            inf        <= 1'b0;
            inf_sign   <= 1'b0;
        end else if (s2_adv) begin
            s2_valid   <= s1_valid;
            big_sign   <= s1_big_sign;
            eff_sub    <= s1_eff_sub;
            exp_out    <= s1_exp;
            mant_big   <= {s1_sig_big, 3'b000};
            mant_small <= small_aligned;
            nan        <= s1_nan;
            inf        <= s1_inf;
            inf_sign   <= s1_inf_sign;
        end
    end

endmodule

// File: doc/fp_align_stage.md
# fp_align_stage

Two-stage pipelined front end of the floating-point adder. Sits directly downstream of the operand memory: it accepts an IEEE-754 single-precision operand pair (A, B), unpacks and classifies both, orders them by magnitude, and right-aligns the smaller significand with guard/round/sticky bits. It presents a common exponent and two aligned 27-bit significands to the add/normalise stage, with valid/ready handshakes on both sides.

## Interface
Parameters:
- none; widths come from the shared package.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (asserted at 0)
- A  input  32  operand A, IEEE-754 single
- B  input  32  operand B, IEEE-754 single
- in_valid  input  1  A/B pair is presented
- in_ready  output  1  stage accepts the pair this cycle; the operand source advances on in_valid & in_ready
- out_valid  output  1  aligned result is valid
- out_ready  input  1  downstream accepts the result
- big_sign  output  1  sign of the larger-magnitude operand
- eff_sub  output  1  sign(A) XOR sign(B)
- exp_out  output  8  effective biased exponent of the larger operand
- mant_big  output  27  {hidden, frac[22:0], 3'b000}
- mant_small  output  27  smaller significand shifted right by the exponent difference, bit 0 sticky
- nan  output  1  result is NaN
- inf  output  1  result is ±infinity; sign given by inf_sign
- inf_sign  output  1  sign of the infinite result

## Operation
- Unpack: hidden = (exp != 0); effective exponent = (exp == 0) ? 1 : exp, so denormals and zeros use exponent 1.
- Classify: NaN = exp 255 and frac != 0; Inf = exp 255 and frac == 0.
- nan = either operand NaN, or both Inf with opposite signs.
- inf = not nan and at least one operand Inf. inf_sign is the sign of the infinite operand.
- Ordering: compare {exp, frac} unsigned. Swap only if |B| > |A|; on a tie, A is the big operand.
- d = eff_exp_big − eff_exp_small (0..254).
- Alignment:
  - If d ≥ 27: mant_small = 27'd1 when the small significand is nonzero, else 0.
  - Otherwise: mant_small = (sig_small << 3) >> d, with bit 0 ORed with every bit shifted out.
- Stage 1 registers: the unpacked and ordered fields, d, and the flags.
- Stage 2 registers: the aligned significands and every output.
- Outputs are driven directly from the stage-2 registers.

## Timing
- Reset (rst = 0): both stage valids clear. out_valid, big_sign, eff_sub, exp_out, mant_big, mant_small, nan, inf and inf_sign are all 0. in_ready is forced to 0 while rst = 0.
- Latency: a pair accepted in cycle N appears on the outputs with out_valid = 1 in cycle N+2. Throughput is one pair per cycle.
- Stage-2 advance: s2_adv = !s2_valid | out_ready.
- Stage-1 advance: s1_adv = !s1_valid | s2_adv.
- in_ready = s1_adv. Ready is combinational from out_ready; there is no skid buffer.
- Stalls: while out_valid = 1 and out_ready = 0, all outputs hold. Capacity is 2 pairs. in_ready falls once both stages hold data.
- Simultaneous events: when a stage is full and its successor advances in the same cycle, the stage loads new data in that same cycle. No bubble is inserted and no pair is dropped or duplicated.
- Reset mid-operation: in-flight pairs are discarded. The first accepted pair after reset release appears 2 cycles later.
- The data registers of an empty stage may change freely. The verifier checks outputs only when out_valid = 1.

## Structure
- Shared package fp_pkg holds:
  - EXP_W = 8, FRAC_W = 23, MANT_W = 27, EXP_MAX = 8'hFF
  - typedef fp_unpacked_t = {sign, exp[7:0], sig[23:0], is_nan, is_inf}
  - The package is reused by the add/normalise and rounding stages.
- One sub-module, fp_rshift_sticky: combinational 27-bit right shifter. Inputs are a value and an 8-bit shift amount; it saturates at 27 and folds all shifted-out bits into bit 0.
- The top level contains unpack/compare, the two pipeline registers and the handshake logic.

## Test plan
- 1.0 + 2.0 (3f800000, 40000000), out_ready = 1 → 2 cycles later:
  - big_sign = 0, eff_sub = 0, exp_out = 8'h80
  - mant_big = 27'h4000000, mant_small = 27'h2000000
- −1.0 + 1.0 (bf800000, 3f800000), tie → A is big:
  - big_sign = 1, eff_sub = 1, exp_out = 8'h7F
  - mant_big = mant_small = 27'h4000000
- 2ac49214 + 6ac49214, d = 128 → exp_out = 8'hD5, mant_big = 27'h6249 0A0, mant_small = 27'h0000001 (sticky only).
- 0 + 0 → exp_out = 8'h01, mant_big = mant_small = 0, nan = 0, inf = 0, eff_sub = 0.
- 7f800000 + ff800000 → nan = 1, inf = 0. 7f800000 + 3f800000 → inf = 1, inf_sign = 0, nan = 0.
- Backpressure and reset, pushing 3 pairs back-to-back with out_ready = 0:
  - in_ready drops after the 2nd pair is accepted; the 3rd pair waits on the inputs.
  - Raising out_ready delivers all 3 pairs in order on consecutive cycles.
  - Pulsing rst low mid-stream clears out_valid immediately.
